// File: rtl/controller_write_pingpong.sv
// Write-side frame buffer controller: packs R,G,B bytes into pixel words and fills buffer 0/1.
// Define PINGPONG_EN for two-buffer alternation; otherwise only buffer 0 is used.
module controller_write_pingpong #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      AIPIn,
  input  logic [3:0]      AILIn,
  input  logic [DW-1:0]   DataIn,
  input  logic            DataValid,
  output logic            DataReady,
  output logic            WE0,
  output logic            WE1,
  output logic [AW-1:0]   WAddr,
  output logic [3*DW-1:0] WData,
  output logic            Buf0Full,
  output logic            Buf1Full,
  input  logic            Buf0Empty,
  input  logic            Buf1Empty
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]      state;
  logic [1:0]      phase;
  logic [DW-1:0]   r_q;
  logic [DW-1:0]   g_q;
  logic [AW-1:0]   addr;
  logic [3:0]      px;
  logic [3:0]      ln;
  logic [3:0]      aip;
  logic [3:0]      ail;
  logic            full0;
  logic            full1;
  logic            tgt;
  logic            we0_q;
  logic [AW-1:0]   waddr_q;
  logic [3*DW-1:0] wdata_q;

  logic tgt_full;
  logic accept;
  logic pix_wr;
  logic frame_end;
  logic size_ok;
  logic other_busy;

  assign tgt_full  = tgt ? full1 : full0;
  assign DataReady = (state == S_FILL) && !tgt_full;
  assign accept    = DataValid && DataReady;
  assign pix_wr    = accept && (phase == 2'd2);
  assign frame_end = pix_wr && (px == aip - 4'd1) && (ln == ail - 4'd1);
  assign size_ok   = (AIPIn != '0) && (AILIn != '0);

  assign WE0      = we0_q;
  assign WAddr    = waddr_q;
  assign WData    = wdata_q;
  assign Buf0Full = full0;

`ifdef PINGPONG_EN
  logic we1_q;

  // Next target is the other buffer; an Empty arriving on the completing edge frees it.
  assign other_busy = tgt ? (full0 && !Buf0Empty) : (full1 && !Buf1Empty);
  assign WE1        = we1_q;
  assign Buf1Full   = full1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tgt   <= 1'b0;
      full1 <= 1'b0;
      we1_q <= 1'b0;
    end else begin
      we1_q <= pix_wr && tgt;
      if (frame_end)
        tgt <= !tgt;
      if (frame_end && tgt)
        full1 <= 1'b1;
      else if (Buf1Empty)
        full1 <= 1'b0;
    end
  end
`else
  logic unused_buf1empty;

  assign unused_buf1empty = Buf1Empty;
  assign other_busy       = 1'b1;
  assign tgt              = 1'b0;
  assign full1            = 1'b0;
  assign WE1              = 1'b0;
  assign Buf1Full         = 1'b0;
`endif

  // Frame-complete set takes priority over a same-edge Empty clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      full0 <= 1'b0;
    else if (frame_end && !tgt)
      full0 <= 1'b1;
    else if (Buf0Empty)
      full0 <= 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      phase   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      addr    <= '0;
      px      <= '0;
      ln      <= '0;
      aip     <= '0;
      ail     <= '0;
      we0_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we0_q <= pix_wr && !tgt;
      case (state)
        S_IDLE: begin
          if (size_ok) begin
            aip   <= AIPIn;
            ail   <= AILIn;
            state <= S_FILL;
          end
        end
        S_WAIT: begin
          if (!tgt_full)
            state <= S_FILL;
        end
        S_FILL: begin
          if (accept) begin
            case (phase)
              2'd0: begin
                r_q   <= DataIn;
                phase <= 2'd1;
              end
              2'd1: begin
                g_q   <= DataIn;
                phase <= 2'd2;
              end
              default: begin
                phase   <= 2'd0;
                waddr_q <= addr;
                wdata_q <= {r_q, g_q, DataIn};
                if (frame_end) begin
                  addr <= '0;
                  px   <= '0;
                  ln   <= '0;
                  aip  <= AIPIn;
                  ail  <= AILIn;
                  if (!size_ok)
                    state <= S_IDLE;
                  else if (other_busy)
                    state <= S_WAIT;
                  else
                    state <= S_FILL;
                end else begin
                  addr <= addr + AW'(1);
                  if (px == aip - 4'd1) begin
                    px <= '0;
                    ln <= ln + 4'd1;
                  end else begin
                    px <= px + 4'd1;
                  end
                end
              end
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_write_pingpong.sv
// Scoreboard bench for controller_write_pingpong; expectations adapt to PINGPONG_EN.
module tb_controller_write_pingpong;

`ifdef PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  AIPIn;
  logic [3:0]  AILIn;
  logic [7:0]  DataIn;
  logic        DataValid;
  logic        DataReady;
  logic        WE0;
  logic        WE1;
  logic [7:0]  WAddr;
  logic [23:0] WData;
  logic        Buf0Full;
  logic        Buf1Full;
  logic        Buf0Empty;
  logic        Buf1Empty;

  always #5 clock = ~clock;

  controller_write_pingpong #(.AW(8), .DW(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .AIPIn     (AIPIn),
    .AILIn     (AILIn),
    .DataIn    (DataIn),
    .DataValid (DataValid),
    .DataReady (DataReady),
    .WE0       (WE0),
    .WE1       (WE1),
    .WAddr     (WAddr),
    .WData     (WData),
    .Buf0Full  (Buf0Full),
    .Buf1Full  (Buf1Full),
    .Buf0Empty (Buf0Empty),
    .Buf1Empty (Buf1Empty)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        b;
    logic [7:0]  a;
    logic [23:0] d;
    logic        last;
  } wr_t;

  wr_t sb[$];
  wr_t e;

  // Reference model of the packing and address sequence
  logic       m_tgt;
  int         m_phase;
  logic [7:0] m_r, m_g, m_addr;
  logic [3:0] m_px, m_ln, m_aip, m_ail;
  logic       m_latch;

  task automatic model_reset();
    m_tgt = 0; m_phase = 0; m_r = 0; m_g = 0; m_addr = 0;
    m_px = 0; m_ln = 0; m_aip = 0; m_ail = 0; m_latch = 1;
  endtask

  task automatic model_accept(input logic [7:0] b);
    logic last;
    if (m_latch) begin
      m_aip = AIPIn; m_ail = AILIn; m_latch = 0;
    end
    if (m_phase == 0) begin
      m_r = b; m_phase = 1;
    end else if (m_phase == 1) begin
      m_g = b; m_phase = 2;
    end else begin
      m_phase = 0;
      last = (m_px == m_aip - 4'd1) && (m_ln == m_ail - 4'd1);
      sb.push_back('{b: m_tgt, a: m_addr, d: {m_r, m_g, b}, last: last});
      if (last) begin
        m_addr = 0; m_px = 0; m_ln = 0;
        m_aip = AIPIn; m_ail = AILIn;
        if (PP) m_tgt = !m_tgt;
      end else begin
        m_addr = m_addr + 8'd1;
        if (m_px == m_aip - 4'd1) begin
          m_px = 0; m_ln = m_ln + 4'd1;
        end else begin
          m_px = m_px + 4'd1;
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && (WE0 || WE1)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_we", {30'b0, WE1, WE0}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("we_buf", {30'b0, WE1, WE0}, e.b ? 32'd2 : 32'd1);
        check_eq("waddr", {24'b0, WAddr}, {24'b0, e.a});
        check_eq("wdata", {8'b0, WData}, {8'b0, e.d});
        if (e.last)
          check_eq("full_align", e.b ? Buf1Full : Buf0Full, 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic [1:0] emp);
    logic acc;
    acc = 0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clock);
      DataValid = 1; DataIn = b;
      Buf0Empty = emp[0] && (i == 0);
      Buf1Empty = emp[1] && (i == 0);
      #1 acc = DataReady;
      @(posedge clock);
      if (acc) model_accept(b);
    end
    if (!acc) check_eq("accept_timeout", {31'b0, acc}, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      DataValid = 0; Buf0Empty = 0; Buf1Empty = 0;
    end
  endtask

  task automatic pulse(input logic [1:0] emp);
    @(negedge clock);
    DataValid = 0; Buf0Empty = emp[0]; Buf1Empty = emp[1];
    @(negedge clock);
    Buf0Empty = 0; Buf1Empty = 0;
    #1;
  endtask

  task automatic send_run(input logic [7:0] start, input int n, input logic gap);
    for (int i = 0; i < n; i++) begin
      send_byte(start + 8'(i), 2'b00);
      if (gap) idle(1);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_ready"}, DataReady, 0);
    check_eq({pfx, "_we0"}, WE0, 0);
    check_eq({pfx, "_we1"}, WE1, 0);
    check_eq({pfx, "_waddr"}, {24'b0, WAddr}, 0);
    check_eq({pfx, "_wdata"}, {8'b0, WData}, 0);
    check_eq({pfx, "_full0"}, Buf0Full, 0);
    check_eq({pfx, "_full1"}, Buf1Full, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    AIPIn = 0; AILIn = 2; DataIn = 0; DataValid = 0;
    Buf0Empty = 0; Buf1Empty = 0;
    model_reset();
    repeat (3) @(negedge clock);
    #1 check_outputs_zero("rst");
    @(negedge clock) reset = 1;

    // Zero pixel count keeps the controller idle
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      #1 if (DataReady) seen = 1;
    end
    check_eq("zero_size_ready", seen, 0);
    AIPIn = 2;
    idle(2);
    #1 check_eq("size_ready", DataReady, 1);

    // Basic 2x2 frame into buffer 0
    send_run(8'h01, 12, 0);
    idle(1);
    #1 check_eq("a_full0", Buf0Full, 1);
    check_eq("a_ready", DataReady, PP);

    if (PP) begin
      send_run(8'h0D, 12, 0);
      idle(1);
      #1 check_eq("b_full1", Buf1Full, 1);
      check_eq("b_wait_ready", DataReady, 0);
    end

    pulse(2'b01);
    check_eq("empty0_clear", Buf0Full, 0);

    // Third frame to buffer 0; buffer-1 Empty lands on its completing edge
    send_run(8'h21, 11, 0);
    AILIn = 1;
    send_byte(8'h2C, 2'b10);
    idle(1);
    #1 check_eq("c_full0", Buf0Full, 1);
    check_eq("c_full1", Buf1Full, 0);
    check_eq("c_ready", DataReady, PP);

    if (!PP) pulse(2'b01);

    // Stalled 2x1 frame
    send_run(8'h31, 6, 1);
    idle(1);
    #1 check_eq("d_full", PP ? Buf1Full : Buf0Full, 1);

    // Reset after R and G of a pixel
    pulse(2'b01);
    send_byte(8'hAA, 2'b00);
    send_byte(8'hBB, 2'b00);
    @(negedge clock);
    DataValid = 0; reset = 0;
    #1 check_outputs_zero("mid_rst");
    model_reset();
    AIPIn = 1; AILIn = 1;
    @(negedge clock) reset = 1;
    send_run(8'h41, 3, 0);
    idle(2);
    #1 check_eq("e_full0", Buf0Full, 1);
    check_eq("e_waddr", {24'b0, WAddr}, 0);
    check_eq("e_wdata", {8'b0, WData}, 32'h414243);
    check_eq("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
